// File: rtl/packet_sequencer_if.sv
// Packet sequencer bus: packet-switch flags, frame-buffer FIFO read side and
// downstream U3 word stream, grouped for the sequencer and its environment.
interface packet_sequencer_if #(
  parameter int REG_WD  = 32,
  parameter int DATA_WD = 64
);
  logic               i_leader_flag;
  logic               i_payload_flag;
  logic               i_trailer_flag;
  logic [REG_WD-1:0]  iv_packet_size;
  logic               i_fifo_empty;
  logic [DATA_WD-1:0] iv_fifo_data;
  logic               i_dst_ready;
  logic               o_fifo_rd;
  logic [DATA_WD-1:0] ov_data;
  logic               o_data_valid;
  logic               o_pkt_end;
  logic               o_change_flag;
  logic [7:0]         ov_roi_num;

  modport master (
    output i_leader_flag, i_payload_flag, i_trailer_flag, iv_packet_size,
    output i_fifo_empty, iv_fifo_data, i_dst_ready,
    input  o_fifo_rd, ov_data, o_data_valid, o_pkt_end, o_change_flag, ov_roi_num
  );

  modport slave (
    input  i_leader_flag, i_payload_flag, i_trailer_flag, iv_packet_size,
    input  i_fifo_empty, iv_fifo_data, i_dst_ready,
    output o_fifo_rd, ov_data, o_data_valid, o_pkt_end, o_change_flag, ov_roi_num
  );
endinterface

// File: rtl/packet_sequencer.sv
// Packet sequencer: moves ceil(size/8) words of each leader/payload/trailer
// from the show-ahead frame FIFO to the U3 interface and signals packet change.
module packet_sequencer #(
  parameter int REG_WD  = 32,
  parameter int DATA_WD = 64
) (
  input  logic               clk,
  input  logic               reset,
  packet_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_XFER = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]         state;
  logic [2:0]         next_state;
  logic               is_leader;
  logic [REG_WD-1:0]  word_cnt;
  logic [REG_WD-1:0]  remaining;
  logic [REG_WD-1:0]  word_idx;
  logic [REG_WD:0]    size_sum;
  logic [REG_WD-1:0]  load_cnt;
  logic               any_flag;
  logic               fifo_rd;
  logic               last_word;
  logic [DATA_WD-1:0] data_q;
  logic               valid_q;
  logic               pkt_end_q;
  logic [7:0]         roi_q;

  // One extra bit keeps size+7 from wrapping for sizes near the top of range.
  assign size_sum = {1'b0, bus.iv_packet_size} + (REG_WD+1)'(7);
  assign load_cnt = {2'b00, size_sum[REG_WD:3]};

  assign any_flag  = bus.i_leader_flag | bus.i_payload_flag | bus.i_trailer_flag;
  assign fifo_rd   = (state == S_XFER) & ~bus.i_fifo_empty & bus.i_dst_ready
                   & (remaining != '0) & ~reset;
  assign last_word = (word_idx == (word_cnt - REG_WD'(1)));

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (any_flag) next_state = S_LOAD;
      S_LOAD:  next_state = (load_cnt != '0) ? S_XFER : S_DONE;
      S_XFER:  if (remaining == '0) next_state = S_DONE;
      S_DONE:  next_state = S_GAP;
      S_GAP:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      is_leader <= 1'b0;
      word_cnt  <= '0;
      remaining <= '0;
      word_idx  <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && any_flag) begin
        is_leader <= bus.i_leader_flag;
      end
      if (state == S_LOAD) begin
        word_cnt  <= load_cnt;
        remaining <= load_cnt;
        word_idx  <= '0;
      end else if (fifo_rd) begin
        remaining <= remaining - REG_WD'(1);
        word_idx  <= word_idx + REG_WD'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      pkt_end_q <= 1'b0;
      roi_q     <= '0;
    end else begin
      valid_q   <= fifo_rd;
      pkt_end_q <= fifo_rd & last_word;
      if (fifo_rd) begin
        data_q <= bus.iv_fifo_data;
      end
      // ROI number sits in the low byte of leader word 2.
      if (fifo_rd && is_leader && word_idx == REG_WD'(2)) begin
        roi_q <= bus.iv_fifo_data[7:0];
      end
    end
  end

  assign bus.o_fifo_rd     = fifo_rd;
  assign bus.ov_data       = data_q;
  assign bus.o_data_valid  = valid_q;
  assign bus.o_pkt_end     = pkt_end_q;
  assign bus.o_change_flag = (state == S_DONE);
  assign bus.ov_roi_num    = roi_q;

endmodule
